iter_shifter: RTL and testbench



---
 rtl/iter_shifter.sv | 131 +++++++++++++
 tb/tb_iter_shifter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// Multi-cycle shifter/rotator (SLL, SRL, SRA, ROR) that moves at most STEP positions per cycle.
// Latency 1 + ceil(shamt/STEP) from accept; one request in flight, result held until out_ready.
module iter_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // STEP may equal WIDTH, which needs one bit more than the shift amount.
    localparam logic [SHAMT_W:0] STEP_LIM = (SHAMT_W+1)'(STEP);

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     work;
    logic [WIDTH-1:0]     work_nxt;
    logic [WIDTH-1:0]     shifted;
    logic [WIDTH-1:0]     out_data_nxt;
    logic [SHAMT_W-1:0]   rem;
    logic [SHAMT_W-1:0]   rem_nxt;
    logic [1:0]           mode;
    logic [1:0]           mode_nxt;
    logic [SHAMT_W:0]     step_amt;

    always_comb begin
        if ({1'b0, rem} < STEP_LIM) begin
            step_amt = {1'b0, rem};
        end else begin
            step_amt = STEP_LIM;
        end
    end

    // A STEP-way mux of constant shifts keeps the datapath narrow.
    always_comb begin
        shifted = work;
        for (int k = 1; k <= STEP; k++) begin
            if (int'(step_amt) == k) begin
                case (mode)
                    MODE_SLL: shifted = work << k;
                    MODE_SRL: shifted = work >> k;
                    MODE_SRA: shifted = WIDTH'($signed(work) >>> k);
                    MODE_ROR: shifted = (work >> k) | (work << (WIDTH - k));
                    default:  shifted = work;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        work_nxt     = work;
        rem_nxt      = rem;
        mode_nxt     = mode;
        out_data_nxt = out_data;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_nxt = in_data;
                    rem_nxt  = in_shamt;
                    mode_nxt = in_mode;
                    if (in_shamt == '0) begin
                        state_nxt    = DONE;
                        out_data_nxt = in_data;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_nxt = shifted;
                rem_nxt  = rem - step_amt[SHAMT_W-1:0];
                if (rem_nxt == '0) begin
                    state_nxt    = DONE;
                    out_data_nxt = shifted;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            work     <= '0;
            rem      <= '0;
            mode     <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nxt;
            work     <= work_nxt;
            rem      <= rem_nxt;
            mode     <= mode_nxt;
            out_data <= out_data_nxt;
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: three instances (STEP 4, 1, 32) share stimulus.
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_mode;
    logic        out_ready;

    logic        ir4, ov4, bz4;
    logic        ir1, ov1, bz1;
    logic        ir32, ov32, bz32;
    logic [31:0] od4, od1, od32;

    int vectors     = 0;
    int miscompares = 0;
    int lat [3];

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .busy(bz4)
    );

    iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(bz1)
    );

    iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(32)) u_s32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(ov32), .out_ready(out_ready), .out_data(od32), .busy(bz32)
    );

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input int m);
        case (m)
            0:       ref_shift = d << s;
            1:       ref_shift = d >> s;
            2:       ref_shift = 32'($signed(d) >>> s);
            default: ref_shift = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
        endcase
    endfunction

    function automatic int ref_lat(input int s, input int step);
        ref_lat = 1 + (s + step - 1) / step;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(ir4 && ir1 && ir32) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (!(ir4 && ir1 && ir32)) begin
            miscompares++;
            $display("FAIL wait_idle: in_ready=%b%b%b required 111", ir4, ir1, ir32);
        end
    endtask

    task automatic launch(input logic [31:0] d, input int s, input int m);
        wait_idle();
        in_data  = d;
        in_shamt = 5'(s);
        in_mode  = 2'(m);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency counts the accept edge as 1; out_ready is held low so results wait.
    task automatic collect();
        for (int i = 0; i < 3; i++) lat[i] = 99;
        for (int n = 1; n <= 80; n++) begin
            if (lat[0] == 99 && ov4)  lat[0] = n;
            if (lat[1] == 99 && ov1)  lat[1] = n;
            if (lat[2] == 99 && ov32) lat[2] = n;
            if (lat[0] != 99 && lat[1] != 99 && lat[2] != 99) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        vectors += 4;
        if (ov4 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b required 0", ov4); end
        if (od4 !== 32'h0) begin miscompares++; $display("FAIL reset_out_data: got %h required 00000000", od4); end
        if (bz4 !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", bz4); end
        if (ir4 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", ir4); end
    endtask

    task automatic test_sll_full();
        int n;
        out_ready = 1'b1;
        launch(32'h0000_0001, 31, 0);
        n = 1;
        while (!ov4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        vectors += 3;
        if (n !== 9) begin miscompares++; $display("FAIL sll31_latency: got %0d required 9", n); end
        if (od4 !== 32'h8000_0000) begin miscompares++; $display("FAIL sll31_data: got %h required 80000000", od4); end
        @(posedge clk); #1;
        if (ov4 !== 1'b0) begin miscompares++; $display("FAIL sll31_valid_pulse: got %b required 0", ov4); end
        wait_idle();
        out_ready = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] d_t [4] = '{32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
        int          s_t [4] = '{4, 31, 8, 0};
        int          m_t [4] = '{2, 1, 3, 1};
        logic [31:0] e_t [4] = '{32'hF800_0000, 32'h0000_0001, 32'h7812_3456, 32'hDEAD_BEEF};
        int          l_t [4] = '{2, 9, 3, 1};
        for (int v = 0; v < 4; v++) begin
            launch(d_t[v], s_t[v], m_t[v]);
            collect();
            vectors += 4;
            if (od4 !== e_t[v]) begin miscompares++; $display("FAIL directed%0d_data4: got %h required %h", v, od4, e_t[v]); end
            if (lat[0] !== l_t[v]) begin miscompares++; $display("FAIL directed%0d_lat4: got %0d required %0d", v, lat[0], l_t[v]); end
            if (od1 !== e_t[v]) begin miscompares++; $display("FAIL directed%0d_data1: got %h required %h", v, od1, e_t[v]); end
            if (od32 !== e_t[v]) begin miscompares++; $display("FAIL directed%0d_data32: got %h required %h", v, od32, e_t[v]); end
            retire();
        end
    endtask

    task automatic test_backpressure();
        launch(32'h0000_00F0, 3, 0);
        collect();
        vectors += 2;
        if (od4 !== 32'h0000_0780) begin miscompares++; $display("FAIL bp_data: got %h required 00000780", od4); end
        if (lat[0] !== 2) begin miscompares++; $display("FAIL bp_lat: got %0d required 2", lat[0]); end
        in_data  = 32'h0000_FFFF;
        in_shamt = 5'd1;
        in_mode  = 2'd0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vectors += 3;
            if (od4 !== 32'h0000_0780) begin miscompares++; $display("FAIL bp_hold_data%0d: got %h required 00000780", c, od4); end
            if (ir4 !== 1'b0) begin miscompares++; $display("FAIL bp_hold_ready%0d: got %b required 0", c, ir4); end
            if (ov4 !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid%0d: got %b required 1", c, ov4); end
        end
        in_valid = 1'b0;
        retire();
        vectors += 2;
        if (ir4 !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after: got %b required 1", ir4); end
        if (ov4 !== 1'b0) begin miscompares++; $display("FAIL bp_valid_after: got %b required 0", ov4); end
        launch(32'hA5A5_0000, 16, 3);
        collect();
        vectors += 2;
        if (od4 !== 32'h0000_A5A5) begin miscompares++; $display("FAIL bp_next_data: got %h required 0000a5a5", od4); end
        if (lat[0] !== 5) begin miscompares++; $display("FAIL bp_next_lat: got %0d required 5", lat[0]); end
        retire();
    endtask

    task automatic test_reset_mid();
        logic seen;
        launch(32'h0000_0001, 20, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vectors += 4;
        if (ov4 !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b required 0", ov4); end
        if (od4 !== 32'h0) begin miscompares++; $display("FAIL rstmid_data: got %h required 00000000", od4); end
        if (bz4 !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b required 0", bz4); end
        if (ir4 !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready: got %b required 1", ir4); end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (ov4 || ov1 || ov32) seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_valid: got %b required 0", seen); end
    endtask

    task automatic test_sweep();
        logic [31:0] d;
        logic [31:0] e;
        for (int m = 0; m < 4; m++) begin
            for (int s = 0; s < 32; s++) begin
                d = (s % 2 == 1) ? (32'hC3A5_0F96 ^ (32'(s) << 7)) : (32'h5A0F_E1B4 + 32'(s) * 32'h0101_0101);
                e = ref_shift(d, s, m);
                launch(d, s, m);
                collect();
                vectors += 6;
                if (od4 !== e) begin miscompares++; $display("FAIL sweep_s4 m%0d s%0d: got %h required %h", m, s, od4, e); end
                if (od1 !== e) begin miscompares++; $display("FAIL sweep_s1 m%0d s%0d: got %h required %h", m, s, od1, e); end
                if (od32 !== e) begin miscompares++; $display("FAIL sweep_s32 m%0d s%0d: got %h required %h", m, s, od32, e); end
                if (lat[0] !== ref_lat(s, 4)) begin miscompares++; $display("FAIL sweep_lat4 m%0d s%0d: got %0d required %0d", m, s, lat[0], ref_lat(s, 4)); end
                if (lat[1] !== ref_lat(s, 1)) begin miscompares++; $display("FAIL sweep_lat1 m%0d s%0d: got %0d required %0d", m, s, lat[1], ref_lat(s, 1)); end
                if (lat[2] !== ref_lat(s, 32)) begin miscompares++; $display("FAIL sweep_lat32 m%0d s%0d: got %0d required %0d", m, s, lat[2], ref_lat(s, 32)); end
                retire();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_sll_full();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
